init_sequencer: RTL and testbench

INIT_SEQUENCER -- requirements
Module: init_sequencer

---
 rtl/init_seq_pkg.sv | 40 ++++
 rtl/init_seq_sync.sv | 21 ++
 rtl/init_sequencer.sv | 147 ++++++++++++++
 tb/tb_init_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/init_seq_pkg.sv
// Shared types and constants for the power-up init sequencer.
package init_seq_pkg;

  typedef enum logic [2:0] {
    ST_POR        = 3'd0,
    ST_WAIT_INIT  = 3'd1,
    ST_WAIT_CALIB = 3'd2,
    ST_WAIT_PLL   = 3'd3,
    ST_STAGE      = 3'd4,
    ST_RUN        = 3'd5,
    ST_FAULT      = 3'd6
  } state_t;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_INIT  = 2'd1;
  localparam logic [1:0] FC_CALIB = 2'd2;
  localparam logic [1:0] FC_PLL   = 2'd3;

  localparam int SYNC_DEPTH = 2;
  localparam int CNT_W      = 24;

  localparam logic [7:0] LLC_MAX = 8'd255;

  // Fault code reported when a WAIT state times out.
  function automatic logic [1:0] fault_code_of(state_t s);
    case (s)
      ST_WAIT_INIT:  return FC_INIT;
      ST_WAIT_CALIB: return FC_CALIB;
      ST_WAIT_PLL:   return FC_PLL;
      default:       return FC_NONE;
    endcase
  endfunction

  // States in which the shared timeout/stage counter runs.
  function automatic logic is_counting(state_t s);
    return (s == ST_WAIT_INIT) || (s == ST_WAIT_CALIB) ||
           (s == ST_WAIT_PLL)  || (s == ST_STAGE);
  endfunction

endpackage

// File: rtl/init_seq_sync.sv
// Single-bit two-flop synchronizer for status inputs from other clock domains.
module init_seq_sync
  import init_seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] sync_q;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_DEPTH-2:0], d};
  end

  assign q = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/init_sequencer.sv
// Power-up init sequencer: walks the fabric through POR, device init,
// bank/transceiver calibration and PLL lock, then releases peripheral and
// core resets in two stages. Any WAIT state that stalls too long lands in
// a sticky FAULT state until software restarts the sequence.
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   POR         | waiting for fabric power-on-reset release
//   WAIT_INIT   | waiting for device init done
//   WAIT_CALIB  | waiting for both bank calibrations and xcvr init
//   WAIT_PLL    | waiting for PLL lock
//   STAGE       | peripherals out of reset, core still held
//   RUN         | everything released, READY high
//   FAULT       | a WAIT state timed out; resets held low
module init_sequencer
  import init_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned STAGE_DELAY    = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fabric_por_n,
  input  logic       device_init_done,
  input  logic       bank_0_calib_status,
  input  logic       bank_1_calib_status,
  input  logic       xcvr_init_done,
  input  logic       pll_lock,
  input  logic       sw_reset,
  output logic       periph_reset_n,
  output logic       core_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state,
  output logic [7:0] lock_loss_cnt
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SD_LAST = CNT_W'(STAGE_DELAY - 1);

  logic por_s, init_s, bank0_s, bank1_s, xcvr_s, lock_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_timeout, stage_done, calib_ok, llc_inc;

  logic       periph_d, core_d, ready_d, fault_d;
  logic [1:0] code_d;
  logic [7:0] llc_d;

  init_seq_sync u_sync_por   (.clk(clk), .reset(reset), .d(fabric_por_n),        .q(por_s));
  init_seq_sync u_sync_init  (.clk(clk), .reset(reset), .d(device_init_done),    .q(init_s));
  init_seq_sync u_sync_bank0 (.clk(clk), .reset(reset), .d(bank_0_calib_status), .q(bank0_s));
  init_seq_sync u_sync_bank1 (.clk(clk), .reset(reset), .d(bank_1_calib_status), .q(bank1_s));
  init_seq_sync u_sync_xcvr  (.clk(clk), .reset(reset), .d(xcvr_init_done),      .q(xcvr_s));
  init_seq_sync u_sync_lock  (.clk(clk), .reset(reset), .d(pll_lock),            .q(lock_s));

  assign at_timeout = (cnt_q == TO_LAST);
  assign stage_done = (cnt_q == SD_LAST);
  assign calib_ok   = bank0_s && bank1_s && xcvr_s;
  assign llc_inc    = (state_q == ST_RUN) && (state_d == ST_WAIT_PLL);

  // State and shared counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_POR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sw_reset, then POR loss, then lock loss, then timeout.
  // Within a WAIT state the exit condition is tested before the timeout.
  always_comb begin
    state_d = state_q;
    if (sw_reset) begin
      state_d = ST_POR;
    end else if ((state_q != ST_POR) && !por_s) begin
      state_d = ST_POR;
    end else begin
      case (state_q)
        ST_POR:        if (por_s) state_d = ST_WAIT_INIT;
        ST_WAIT_INIT:  if (init_s)          state_d = ST_WAIT_CALIB;
                       else if (at_timeout) state_d = ST_FAULT;
        ST_WAIT_CALIB: if (calib_ok)        state_d = ST_WAIT_PLL;
                       else if (at_timeout) state_d = ST_FAULT;
        ST_WAIT_PLL:   if (lock_s)          state_d = ST_STAGE;
                       else if (at_timeout) state_d = ST_FAULT;
        ST_STAGE:      if (!lock_s)         state_d = ST_WAIT_PLL;
                       else if (stage_done) state_d = ST_RUN;
        ST_RUN:        if (!lock_s)         state_d = ST_WAIT_PLL;
        ST_FAULT:      state_d = ST_FAULT;
        default:       state_d = ST_POR;
      endcase
    end
  end

  // Counter restarts at zero on every state change and runs while waiting/staging.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && is_counting(state_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Output values for the upcoming state; registered below so they change
  // on the same edge as the state.
  always_comb begin
    periph_d = (state_d == ST_STAGE) || (state_d == ST_RUN);
    core_d   = (state_d == ST_RUN);
    ready_d  = (state_d == ST_RUN);
    fault_d  = fault;
    code_d   = fault_code;
    llc_d    = lock_loss_cnt;
    if (sw_reset) begin
      fault_d = 1'b0;
      code_d  = FC_NONE;
    end else if ((state_d == ST_FAULT) && (state_q != ST_FAULT)) begin
      fault_d = 1'b1;
      code_d  = fault_code_of(state_q);
    end
    if (llc_inc && (lock_loss_cnt != LLC_MAX)) llc_d = lock_loss_cnt + 8'd1;
  end

  // Output registers; async reset drops both resets without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      periph_reset_n <= 1'b0;
      core_reset_n   <= 1'b0;
      ready          <= 1'b0;
      fault          <= 1'b0;
      fault_code     <= FC_NONE;
      state          <= 3'd0;
      lock_loss_cnt  <= 8'd0;
    end else begin
      periph_reset_n <= periph_d;
      core_reset_n   <= core_d;
      ready          <= ready_d;
      fault          <= fault_d;
      fault_code     <= code_d;
      state          <= state_d;
      lock_loss_cnt  <= llc_d;
    end
  end

endmodule

// File: tb/tb_init_sequencer.sv
// Scoreboard bench for init_sequencer with TIMEOUT_CYCLES=16, STAGE_DELAY=4.
// Expectations are stamped with the clock cycle at which the outputs must
// show them and are compared on the falling edge of that cycle.
module tb_init_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       fabric_por_n, device_init_done, bank_0_calib_status;
  logic       bank_1_calib_status, xcvr_init_done, pll_lock, sw_reset;
  logic       periph_reset_n, core_reset_n, ready, fault;
  logic [1:0] fault_code;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int    cyc;
    string tag;
    int    st, prn, crn, rdy, flt, fc, llc;
  } exp_t;

  exp_t sb[$];

  init_sequencer #(.TIMEOUT_CYCLES(16), .STAGE_DELAY(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .fabric_por_n        (fabric_por_n),
    .device_init_done    (device_init_done),
    .bank_0_calib_status (bank_0_calib_status),
    .bank_1_calib_status (bank_1_calib_status),
    .xcvr_init_done      (xcvr_init_done),
    .pll_lock            (pll_lock),
    .sw_reset            (sw_reset),
    .periph_reset_n      (periph_reset_n),
    .core_reset_n        (core_reset_n),
    .ready               (ready),
    .fault               (fault),
    .fault_code          (fault_code),
    .state               (state),
    .lock_loss_cnt       (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int at, input string tag, input int st, input int prn,
                      input int crn, input int rdy, input int flt, input int fc,
                      input int llc);
    exp_t e;
    e.cyc = at; e.tag = tag; e.st = st; e.prn = prn; e.crn = crn;
    e.rdy = rdy; e.flt = flt; e.fc = fc; e.llc = llc;
    sb.push_back(e);
  endtask

  task automatic sb_compare_head();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, ".state"},  int'(state),          e.st);
    check({e.tag, ".periph"}, int'(periph_reset_n), e.prn);
    check({e.tag, ".core"},   int'(core_reset_n),   e.crn);
    check({e.tag, ".ready"},  int'(ready),          e.rdy);
    check({e.tag, ".fault"},  int'(fault),          e.flt);
    check({e.tag, ".fcode"},  int'(fault_code),     e.fc);
    check({e.tag, ".llc"},    int'(lock_loss_cnt),  e.llc);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) sb_compare_head();
  end

  task automatic go(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_st(input int tgt, input int budget, input string tag);
    int n = 0;
    while (int'(state) != tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(state), tgt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    reset = 1'b1;
    fabric_por_n = 1'b0; device_init_done = 1'b0; bank_0_calib_status = 1'b0;
    bank_1_calib_status = 1'b0; xcvr_init_done = 1'b0; pll_lock = 1'b0;
    sw_reset = 1'b0;

    @(negedge clk); #1;
    push(cyc, "rst", 0, 0, 0, 0, 0, 0, 0);
    sb_compare_head();
    @(negedge clk);
    reset = 1'b0;
    go(2);

    // All status inputs rise together.
    m = cyc;
    fabric_por_n = 1'b1; device_init_done = 1'b1; bank_0_calib_status = 1'b1;
    bank_1_calib_status = 1'b1; xcvr_init_done = 1'b1; pll_lock = 1'b1;
    push(m + 2,  "up_por",   0, 0, 0, 0, 0, 0, 0);
    push(m + 3,  "up_init",  1, 0, 0, 0, 0, 0, 0);
    push(m + 4,  "up_calib", 2, 0, 0, 0, 0, 0, 0);
    push(m + 5,  "up_pll",   3, 0, 0, 0, 0, 0, 0);
    push(m + 6,  "up_stage", 4, 1, 0, 0, 0, 0, 0);
    push(m + 9,  "up_stg_e", 4, 1, 0, 0, 0, 0, 0);
    push(m + 10, "up_run",   5, 1, 1, 1, 0, 0, 0);
    go(11);

    // Three lock losses in RUN, each relocked.
    for (int k = 1; k <= 3; k++) begin
      m = cyc;
      pll_lock = 1'b0;
      push(m + 2, "ll_run",  5, 1, 1, 1, 0, 0, k - 1);
      push(m + 3, "ll_wait", 3, 0, 0, 0, 0, 0, k);
      go(3);
      pll_lock = 1'b1;
      push(m + 6,  "ll_stage", 4, 1, 0, 0, 0, 0, k);
      push(m + 10, "ll_rerun", 5, 1, 1, 1, 0, 0, k);
      go(8);
    end

    // Fabric POR drops while in STAGE.
    m = cyc;
    pll_lock = 1'b0;
    push(m + 3, "pd_wait", 3, 0, 0, 0, 0, 0, 4);
    go(3);
    pll_lock = 1'b1;
    push(m + 6, "pd_stage", 4, 1, 0, 0, 0, 0, 4);
    go(3);
    fabric_por_n = 1'b0;
    push(m + 8, "pd_hold", 4, 1, 0, 0, 0, 0, 4);
    push(m + 9, "pd_por",  0, 0, 0, 0, 0, 0, 4);
    go(3);
    fabric_por_n = 1'b1;
    wait_st(5, 40, "pd_recover");

    // Calibration timeout on bank 1, then software restart.
    go(1);
    m = cyc;
    bank_1_calib_status = 1'b0;
    sw_reset = 1'b1;
    push(m + 1,  "ct_por",    0, 0, 0, 0, 0, 0, 4);
    push(m + 2,  "ct_init",   1, 0, 0, 0, 0, 0, 4);
    push(m + 3,  "ct_calib",  2, 0, 0, 0, 0, 0, 4);
    push(m + 18, "ct_last",   2, 0, 0, 0, 0, 0, 4);
    push(m + 19, "ct_fault",  6, 0, 0, 0, 1, 2, 4);
    push(m + 21, "ct_hold",   6, 0, 0, 0, 1, 2, 4);
    push(m + 22, "ct_swr",    0, 0, 0, 0, 0, 0, 4);
    go(1);
    sw_reset = 1'b0;
    go(20);
    sw_reset = 1'b1;
    go(1);
    sw_reset = 1'b0;
    bank_1_calib_status = 1'b1;
    wait_st(5, 40, "ct_recover");

    // Lock returns in the very cycle the WAIT_PLL timeout fires: exit wins.
    go(1);
    m = cyc;
    pll_lock = 1'b0;
    push(m + 3,  "et_wait",  3, 0, 0, 0, 0, 0, 5);
    push(m + 18, "et_last",  3, 0, 0, 0, 0, 0, 5);
    push(m + 19, "et_stage", 4, 1, 0, 0, 0, 0, 5);
    push(m + 23, "et_run",   5, 1, 1, 1, 0, 0, 5);
    go(16);
    pll_lock = 1'b1;
    go(8);

    // One cycle later the same scenario must fault with the PLL code.
    m = cyc;
    pll_lock = 1'b0;
    push(m + 3,  "lt_wait",  3, 0, 0, 0, 0, 0, 6);
    push(m + 18, "lt_last",  3, 0, 0, 0, 0, 0, 6);
    push(m + 19, "lt_fault", 6, 0, 0, 0, 1, 3, 6);
    push(m + 21, "lt_swr",   0, 0, 0, 0, 0, 0, 6);
    go(17);
    pll_lock = 1'b1;
    go(3);
    sw_reset = 1'b1;
    go(1);
    sw_reset = 1'b0;
    wait_st(5, 40, "lt_recover");

    // 300 more lock losses saturate the counter.
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      wait_st(3, 10, "sat_drop");
      pll_lock = 1'b1;
      wait_st(5, 20, "sat_relock");
    end
    go(1);
    m = cyc;
    push(m + 1, "sat_llc", 5, 1, 1, 1, 0, 0, 255);
    go(2);

    // Asynchronous reset mid-STAGE, away from any clock edge.
    pll_lock = 1'b0;
    wait_st(3, 10, "ar_drop");
    pll_lock = 1'b1;
    wait_st(4, 10, "ar_stage");
    check("ar_pre_periph", int'(periph_reset_n), 1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    push(cyc, "ar", 0, 0, 0, 0, 0, 0, 0);
    sb_compare_head();
    @(negedge clk);
    reset = 1'b0;
    go(2);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
